// File: rtl/serial_word_feeder.sv
// Serializes WIDTH-bit words onto a single bit stream, with a one-word holding register
// so that consecutive words leave no gap between them.
module serial_word_feeder #(
    parameter int unsigned WIDTH     = 11,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_valid_q;

    logic          accept;
    logic          last_bit;
    logic [CW-1:0] bit_idx;

    assign load_ready = ~pend_valid_q;
    assign accept     = load_valid & load_ready;
    assign last_bit   = (state_q == StShift) & (count_q == LAST) & shift_en;
    assign bit_idx    = LSB_FIRST ? count_q : (LAST - count_q);

    assign dout_valid = (state_q == StShift);
    assign dout       = dout_valid & shreg_q[bit_idx];
    // A word cut short by reset never reports completion.
    assign word_done  = last_bit & ~reset;
    assign busy       = dout_valid | pend_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        shreg_q <= load_data;
                        count_q <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (last_bit) begin
                        count_q <= '0;
                        if (pend_valid_q) begin
                            shreg_q      <= pend_q;
                            pend_valid_q <= 1'b0;
                        end else if (accept) begin
                            shreg_q <= load_data;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        if (shift_en) begin
                            count_q <= count_q + CW'(1);
                        end
                        if (accept) begin
                            pend_q       <= load_data;
                            pend_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench: accepted words expand into a queue of expected bits that a negedge
// monitor consumes; an LSB-first and an MSB-first instance see identical stimulus.
module tb_serial_word_feeder;

    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] load_data = '0;

    logic rdy_l, dout_l, dv_l, wd_l, busy_l;
    logic rdy_m, dout_m, dv_m, wd_m, busy_m;

    serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .dout       (dout_l),
        .dout_valid (dv_l),
        .word_done  (wd_l),
        .busy       (busy_l)
    );

    serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .dout       (dout_m),
        .dout_valid (dv_m),
        .word_done  (wd_m),
        .busy       (busy_m)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b_lsb;
        logic b_msb;
        logic last;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int       checks = 0;
    int       errors = 0;
    bit       checking = 1'b0;
    bit       model_ready = 1'b1;
    bit       exp_wd;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Queue holds every bit still owed; more than one word's worth means the holding
    // register is occupied.
    always @(negedge clk) begin
        model_ready = (exp_q.size() <= W);
        if (checking) begin
            check("load_ready_lsb", rdy_l, model_ready);
            check("load_ready_msb", rdy_m, model_ready);
            check("busy_lsb", busy_l, exp_q.size() > 0);
            check("busy_msb", busy_m, exp_q.size() > 0);
            check("dout_valid_lsb", dv_l, exp_q.size() > 0);
            check("dout_valid_msb", dv_m, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                exp_wd = shift_en && exp_q[0].last && !reset;
                check("dout_lsb", dout_l, exp_q[0].b_lsb);
                check("dout_msb", dout_m, exp_q[0].b_msb);
                check("word_done_lsb", wd_l, exp_wd);
                check("word_done_msb", wd_m, exp_wd);
            end else begin
                check("idle_dout_lsb", dout_l, 1'b0);
                check("idle_dout_msb", dout_m, 1'b0);
                check("idle_word_done_lsb", wd_l, 1'b0);
                check("idle_word_done_msb", wd_m, 1'b0);
            end
        end
        if (exp_q.size() > 0 && shift_en) begin
            void'(exp_q.pop_front());
        end
    end

    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back('{b_lsb: d[i], b_msb: d[W-1-i], last: (i == W - 1)});
        end
    endtask

    task automatic step(input logic lv, input logic [W-1:0] d, input logic se,
                        input logic rst);
        load_valid = lv;
        load_data  = d;
        shift_en   = se;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else if (lv && model_ready) begin
            push_word(d);
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, W'($urandom), 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        w = 11'b10101001010;

        step(1'b1, W'($urandom), 1'b1, 1'b1);
        step(1'b1, W'($urandom), 1'b1, 1'b1);
        checking = 1'b1;

        // Single word, then back to idle.
        step(1'b1, w, 1'b1, 1'b0);
        run(14);

        // Back-to-back: second word pends at bit 3, third keeps requesting.
        step(1'b1, W'($urandom), 1'b1, 1'b0);
        run(3);
        step(1'b1, w, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'($urandom), 1'b1, 1'b0);
        end
        run(40);

        // Stall three cycles at bit 4.
        step(1'b1, W'($urandom), 1'b1, 1'b0);
        run(4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, W'($urandom), 1'b0, 1'b0);
        end
        run(12);

        // Reset at bit 5 with a word pending; load_valid during reset is ignored.
        step(1'b1, W'($urandom), 1'b1, 1'b0);
        step(1'b1, W'($urandom), 1'b1, 1'b0);
        run(4);
        step(1'b0, W'($urandom), 1'b1, 1'b1);
        step(1'b1, W'($urandom), 1'b1, 1'b1);
        run(3);

        // Accept on the last-bit cycle with the holding register empty.
        step(1'b1, W'($urandom), 1'b1, 1'b0);
        run(10);
        step(1'b1, w, 1'b1, 1'b0);
        run(14);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, W'($urandom), ($urandom % 4) != 0,
                 ($urandom % 250) == 0);
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b0, W'($urandom), ($urandom % 4) != 0, 1'b0);
        end
        run(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 Parameter: WIDTH, default 11, bits per word.
REQ-002 Parameter: LSB_FIRST, default 1; 1 = bit 0 sent first, 0 = bit WIDTH-1 sent first.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: load_valid  input  1  load_data holds a word to send.
REQ-006 Port: load_ready  output  1  block can accept a word this cycle.
REQ-007 Port: load_data  input  WIDTH  parallel word to serialize.
REQ-008 Port: shift_en  input  1  advance enable; 0 freezes the bit stream.
REQ-009 Port: dout  output  1  serial bit; drives the downstream sequence detector's din.
REQ-010 Port: dout_valid  output  1  dout carries a live word bit.
REQ-011 Port: word_done  output  1  one-cycle pulse during the last bit of a word.
REQ-012 Port: busy  output  1  high whenever a word is shifting or pending.

Function
REQ-013 Word accepted on a rising edge where load_valid=1 and load_ready=1; otherwise load_data is ignored.
REQ-014 load_ready SHALL equal NOT pend_valid, where pend_valid flags a one-word holding register.
REQ-015 FSM has two states: IDLE and SHIFT.
REQ-016 IDLE outputs: dout=0, dout_valid=0, word_done=0.
REQ-017 IDLE transition: an accept loads the word directly into the shift register, clears bit counter to 0, and enters SHIFT at the same edge.
REQ-018 Latency: the first bit is on dout in the cycle immediately after the accepting edge (1 cycle).
REQ-019 SHIFT outputs: dout_valid=1; dout = current bit (bit index = count if LSB_FIRST=1, else WIDTH-1-count).
REQ-020 SHIFT with shift_en=1: count increments each edge.
REQ-021 SHIFT with shift_en=0: count, shift register and dout hold; dout_valid stays 1; word_done stays 0.
REQ-022 word_done=1 only in the cycle where count=WIDTH-1 and shift_en=1.
REQ-023 Last-bit edge (count=WIDTH-1, shift_en=1) with pend_valid=1: pending word moves to the shift register, count=0, pend_valid clears, stay in SHIFT (zero gap).
REQ-024 Last-bit edge with pend_valid=0 and simultaneous accept: new word goes straight to the shift register, count=0, stay in SHIFT (zero gap).
REQ-025 Last-bit edge with pend_valid=0 and no accept: return to IDLE.
REQ-026 Accept in SHIFT, other than REQ-024: word stored in the holding register, pend_valid set; load_ready drops the next cycle.
REQ-027 busy = (state==SHIFT) OR pend_valid.
REQ-028 The counter SHALL be ceil(log2(WIDTH)) bits wide, with no wrap beyond WIDTH-1.

Reset
REQ-029 reset=1 at an edge forces IDLE, count=0, shift register=0 and pend_valid=0.
REQ-030 Reset has priority over accept and over shifting; a word in progress or pending is discarded with no word_done.
REQ-031 Reset values: dout=0, dout_valid=0, word_done=0, busy=0.
REQ-032 load_ready=1 from the first cycle after reset deasserts.
REQ-033 load_valid SHALL be ignored while reset=1.

Verification
REQ-034 Single word: WIDTH=11, LSB_FIRST=1, load 11'b10101001010, shift_en=1.
- Required: dout = 0,1,0,1,0,0,1,0,1,0,1 over 11 consecutive cycles.
- Required: word_done on the 11th bit, then IDLE.
REQ-035 Back-to-back: a second word loaded while the first shifts.
- Required: the first bit of word 2 directly follows the last bit of word 1, no gap.
- Required: load_ready=0 from the cycle after the pending accept until the hand-over edge.
REQ-036 Stall: shift_en=0 for 3 cycles at bit 4.
- Required: dout and dout_valid hold for 3 cycles.
- Required: the total word spans 14 cycles; word_done is a single pulse.
REQ-037 Reset mid-word: reset at bit 5 with a word pending.
- Required: the next cycle shows dout_valid=0, busy=0, load_ready=1, and no word_done.
REQ-038 LSB_FIRST=0: load 11'b10101001010.
- Required: dout = 1,0,1,0,1,0,0,1,0,1,0.
REQ-039 Last-bit accept: load_valid on the last-bit cycle with the holding register empty.
- Required: zero-gap continuation; pend_valid stays 0.
